// File: rtl/nibble_stim_sequencer.sv
// nibble_stim_sequencer: clocked, restartable, pausable nibble stepper START_VAL..END_VAL, each held HOLD_CYCLES clocks.
// Define NIBBLE_SEQ_LOOP_EN to wrap END_VAL->START_VAL forever instead of stopping in DONE.
module nibble_stim_sequencer #(
  parameter int HOLD_CYCLES = 10,
  parameter int START_VAL = 0,
  parameter int END_VAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pause,
  input  logic abort,
  output logic x3,
  output logic x2,
  output logic x1,
  output logic x0,
  output logic valid,
  output logic step,
  output logic done,
  output logic wrap
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0] SV = 4'(START_VAL);
  localparam logic [3:0] EV = 4'(END_VAL);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [3:0] nib, nib_n;
  logic [CW-1:0] cnt, cnt_n;
  logic valid_n, step_n, done_n, wrap_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nib   <= SV;
      cnt   <= '0;
      valid <= 1'b0;
      step  <= 1'b0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      nib   <= nib_n;
      cnt   <= cnt_n;
      valid <= valid_n;
      step  <= step_n;
      done  <= done_n;
      wrap  <= wrap_n;
    end
  end
  always_comb begin
    state_n = state;
    nib_n   = nib;
    cnt_n   = cnt;
    valid_n = valid;
    step_n  = 1'b0;
    done_n  = done;
    wrap_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      nib_n   = SV;
      cnt_n   = '0;
      valid_n = 1'b0;
      done_n  = 1'b0;
    end else if (start && state != RUN) begin
      state_n = RUN;
      nib_n   = SV;
      cnt_n   = '0;
      valid_n = 1'b1;
      step_n  = 1'b1;
      done_n  = 1'b0;
    end else if (state == RUN && !pause) begin
      if (cnt != LAST) cnt_n = cnt + 1'b1;
      else if (nib != EV) begin
        nib_n  = nib + 4'd1;
        cnt_n  = '0;
        step_n = 1'b1;
      end else begin
`ifdef NIBBLE_SEQ_LOOP_EN
        nib_n  = SV;
        cnt_n  = '0;
        step_n = 1'b1;
        wrap_n = 1'b1;
`else
        state_n = DONE;
        valid_n = 1'b0;
        done_n  = 1'b1;
`endif
      end
    end
  end
  assign {x3, x2, x1, x0} = nib;
endmodule

// File: tb/tb_nibble_stim_sequencer.sv
// tb_nibble_stim_sequencer: three parameterisations driven together, checked against an elapsed-cycle arithmetic model.
module tb_nibble_stim_sequencer;
`ifdef NIBBLE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, pause, abort;
  wire [7:0] oa, ob, oc;
  int checks = 0;
  int failures = 0;
  int hp[3] = '{10, 1, 2};
  int sp[3] = '{0, 3, 0};
  int ep[3] = '{15, 5, 15};
  typedef struct {int mode; int a; bit step; bit wrap;} m_t;
  m_t m[3];
  always #5 clk = ~clk;
  nibble_stim_sequencer #(.HOLD_CYCLES(10), .START_VAL(0), .END_VAL(15)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .x3(oa[7]), .x2(oa[6]), .x1(oa[5]), .x0(oa[4]),
    .valid(oa[3]), .step(oa[2]), .done(oa[1]), .wrap(oa[0]));
  nibble_stim_sequencer #(.HOLD_CYCLES(1), .START_VAL(3), .END_VAL(5)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .x3(ob[7]), .x2(ob[6]), .x1(ob[5]), .x0(ob[4]),
    .valid(ob[3]), .step(ob[2]), .done(ob[1]), .wrap(ob[0]));
  nibble_stim_sequencer #(.HOLD_CYCLES(2), .START_VAL(0), .END_VAL(15)) dut_c (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .x3(oc[7]), .x2(oc[6]), .x1(oc[5]), .x0(oc[4]),
    .valid(oc[3]), .step(oc[2]), .done(oc[1]), .wrap(oc[0]));
  // mode: 0 idle, 1 run, 2 done; a = unpaused run edges since the last start
  function automatic m_t nxt(m_t c, int h, int s, int e, bit ab, bit st, bit pa);
    m_t r;
    int n;
    r = c;
    n = e - s + 1;
    r.step = 1'b0;
    r.wrap = 1'b0;
    if (ab) begin
      r.mode = 0;
      r.a = 0;
    end else if (st && c.mode != 1) begin
      r.mode = 1;
      r.a = 0;
      r.step = 1'b1;
    end else if (c.mode == 1 && !pa) begin
      r.a = c.a + 1;
      if (!LOOP && r.a == n * h) r.mode = 2;
      else begin
        r.step = (r.a % h == 0);
        r.wrap = LOOP && (r.a % (n * h) == 0);
      end
    end
    return r;
  endfunction
  function automatic logic [7:0] expv(int i);
    logic [3:0] nb;
    int n;
    n = ep[i] - sp[i] + 1;
    nb = m[i].mode == 1 ? 4'(sp[i] + (m[i].a / hp[i]) % n) : m[i].mode == 2 ? 4'(ep[i]) : 4'(sp[i]);
    return {nb, m[i].mode == 1, m[i].step, m[i].mode == 2, m[i].wrap};
  endfunction
  function automatic logic [7:0] obs(int i);
    return i == 0 ? oa : i == 1 ? ob : oc;
  endfunction
  task automatic tick(bit r, bit st, bit pa, bit ab);
    rst = r; start = st; pause = pa; abort = ab;
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = r ? '{0, 0, 1'b0, 1'b0} : nxt(m[i], hp[i], sp[i], ep[i], ab, st, pa);
    #1;
  endtask
  task automatic test_reset;
    tick(1, 0, 0, 0);
    tick(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== expv(i)) begin failures++; $display("FAIL reset[%0d] got=%h exp=%h", i, obs(i), expv(i)); end
    end
    checks++;
    if (oa !== 8'h00) begin failures++; $display("FAIL reset_a got=%h exp=00", oa); end
  endtask
  task automatic test_full_sequence;
    int steps, done_at;
    steps = 0;
    done_at = -1;
    for (int t = 1; t <= 170; t++) begin
      tick(0, t == 1, 0, 0);
      checks++;
      if (oa !== expv(0)) begin failures++; $display("FAIL full t=%0d got=%h exp=%h", t, oa, expv(0)); end
      if (oa[2]) steps++;
      if (oa[1] && done_at < 0) done_at = t;
    end
    checks++;
    if (steps != 16) begin failures++; $display("FAIL full_steps got=%0d exp=16", steps); end
    checks++;
    if (done_at != 161) begin failures++; $display("FAIL full_done_at got=%0d exp=161", done_at); end
    checks++;
    if (oa[7:4] !== 4'd15) begin failures++; $display("FAIL full_hold_end got=%0d exp=15", oa[7:4]); end
  endtask
  task automatic test_short;
    logic [3:0] seq[3];
    for (int t = 1; t <= 5; t++) begin
      tick(0, t == 1, 0, 0);
      checks++;
      if (ob !== expv(1)) begin failures++; $display("FAIL short t=%0d got=%h exp=%h", t, ob, expv(1)); end
      if (t <= 3) seq[t-1] = ob[7:4];
    end
    checks++;
    if (seq[0] !== 4'd3 || seq[1] !== 4'd4 || seq[2] !== 4'd5) begin
      failures++; $display("FAIL short_seq got=%0d,%0d,%0d exp=3,4,5", seq[0], seq[1], seq[2]);
    end
    checks++;
    if (ob[1] !== 1'b1 || ob[3] !== 1'b0) begin failures++; $display("FAIL short_done got=%h exp=done", ob); end
  endtask
  task automatic test_pause;
    int held;
    held = 0;
    for (int t = 1; t <= 100; t++) begin
      tick(0, t == 1, t >= 74 && t <= 78, 0);
      checks++;
      if (oa !== expv(0)) begin failures++; $display("FAIL pause t=%0d got=%h exp=%h", t, oa, expv(0)); end
      if (oa[3] && oa[7:4] == 4'd7) held++;
    end
    checks++;
    if (held != 15) begin failures++; $display("FAIL pause_hold7 got=%0d exp=15", held); end
  endtask
  task automatic test_abort;
    for (int t = 1; t <= 20; t++) tick(0, t == 1, 0, 0);
    tick(0, 1, 0, 1);
    checks++;
    if (oa !== 8'h00) begin failures++; $display("FAIL abort_run got=%h exp=00", oa); end
    checks++;
    if (ob !== expv(1)) begin failures++; $display("FAIL abort_b got=%h exp=%h", ob, expv(1)); end
    tick(0, 0, 0, 0);
    checks++;
    if (oa !== 8'h00) begin failures++; $display("FAIL abort_idle got=%h exp=00", oa); end
  endtask
  task automatic test_restart_done;
    for (int t = 1; t <= 4; t++) tick(0, t == 1, 0, 0);
    checks++;
    if (ob[1] !== 1'b1) begin failures++; $display("FAIL restart_pre got=%h exp=done", ob); end
    tick(0, 1, 0, 0);
    checks++;
    if (ob !== {4'd3, 4'b1100}) begin failures++; $display("FAIL restart got=%h exp=%h", ob, {4'd3, 4'b1100}); end
  endtask
  task automatic test_loop;
    int wraps, dones;
    tick(1, 0, 0, 0);
    wraps = 0;
    dones = 0;
    for (int t = 1; t <= 100; t++) begin
      tick(0, t == 1, 0, 0);
      checks++;
      if (oc !== expv(2)) begin failures++; $display("FAIL loop t=%0d got=%h exp=%h", t, oc, expv(2)); end
      if (oc[0]) wraps++;
      if (oc[1]) dones++;
`ifdef NIBBLE_SEQ_LOOP_EN
      if (t == 33) begin
        checks++;
        if (oc !== 8'b0000_1101) begin failures++; $display("FAIL loop_wrap got=%h exp=0d", oc); end
      end
`endif
    end
`ifdef NIBBLE_SEQ_LOOP_EN
    checks++;
    if (wraps != 3 || dones != 0) begin failures++; $display("FAIL loop_count wraps=%0d dones=%0d exp=3,0", wraps, dones); end
`else
    checks++;
    if (wraps != 0 || dones != 68) begin failures++; $display("FAIL oneshot_c wraps=%0d dones=%0d exp=0,68", wraps, dones); end
`endif
  endtask
  task automatic test_random;
    for (int t = 0; t < 3000; t++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin failures++; $display("FAIL random[%0d] t=%0d got=%h exp=%h", i, t, obs(i), expv(i)); end
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 1'b0, 1'b0};
    test_reset;
    test_full_sequence;
    test_short;
    test_pause;
    test_abort;
    test_restart_done;
    test_loop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
